sim_run_ctrl: RTL



---
 rtl/sim_ctrl_pkg.sv | 28 ++
 rtl/sim_watchdog.sv | 35 +++
 rtl/sim_run_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation run controller: FSM state encoding,
// termination cause codes and the trap-code decode helper.
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

  localparam logic [2:0] EXIT_NONE       = 3'd0;
  localparam logic [2:0] EXIT_GOOD_TRAP  = 3'd1;
  localparam logic [2:0] EXIT_BAD_TRAP   = 3'd2;
  localparam logic [2:0] EXIT_DIFF_ERR   = 3'd3;
  localparam logic [2:0] EXIT_STALL      = 3'd4;
  localparam logic [2:0] EXIT_MAX_CYCLES = 3'd5;

  function automatic logic [2:0] trap_exit(input logic [7:0] code);
    if (code == 8'd0) begin
      return EXIT_GOOD_TRAP;
    end else begin
      return EXIT_BAD_TRAP;
    end
  endfunction

endpackage

// File: rtl/sim_watchdog.sv
// Saturating commit-stall counter; expired is high once LIMIT-1 consecutive
// commit-free cycles have been counted.
module sim_watchdog
  import sim_ctrl_pkg::*;
#(
  parameter int LIMIT = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] TOP = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_r;

  // stall counter: clear wins over increment, saturates at TOP
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != TOP)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == TOP);

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: sequences core reset and difftest init, gates stepping,
// counts cycles/instructions and ends the run on the first terminating event.
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int RESET_HOLD   = 50,
  parameter int STALL_LIMIT  = 5000,
  parameter int DRAIN_CYCLES = 4,
  parameter int COMMIT_W     = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [31:0]                    cfg_max_cycles,
  input  logic [$clog2(COMMIT_W+1)-1:0]  commit_cnt,
  input  logic                           trap_valid,
  input  logic [7:0]                     trap_code,
  input  logic                           step_err,
  output logic                           core_reset,
  output logic                           init_req,
  output logic                           step_en,
  output logic                           finish,
  output logic [2:0]                     exit_code,
  output logic [63:0]                    cycle_cnt,
  output logic [63:0]                    instr_cnt
);

  localparam int CCW     = $clog2(COMMIT_W + 1);
  localparam int HOLD_W  = $clog2(RESET_HOLD + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  run_state_e          state_r;
  run_state_e          state_s;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic [DRAIN_W-1:0]  drain_cnt_r;
  logic [31:0]         max_cycles_r;
  logic [63:0]         cycle_cnt_r;
  logic [63:0]         instr_cnt_r;
  logic [2:0]          exit_code_r;
  logic [2:0]          term_code_s;
  logic                term_s;
  logic                stall_expired_s;
  logic                no_commit_s;
  logic                in_run_s;

  assign in_run_s    = (state_r == ST_RUN);
  assign no_commit_s = (commit_cnt == CCW'(0));

  sim_watchdog #(
    .LIMIT (STALL_LIMIT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   ((state_r == ST_INIT) || (in_run_s && !no_commit_s)),
    .inc     (in_run_s && no_commit_s),
    .expired (stall_expired_s)
  );

  // termination cause for this RUN cycle, highest priority first
  always_comb begin
    term_code_s = EXIT_NONE;
    if (step_err) begin
      term_code_s = EXIT_DIFF_ERR;
    end else if (trap_valid) begin
      term_code_s = trap_exit(trap_code);
    end else if (stall_expired_s && no_commit_s) begin
      term_code_s = EXIT_STALL;
    end else if ((max_cycles_r != 32'd0) &&
                 ((cycle_cnt_r + 64'd1) == {32'd0, max_cycles_r})) begin
      term_code_s = EXIT_MAX_CYCLES;
    end else begin
      term_code_s = EXIT_NONE;
    end
  end

  assign term_s = in_run_s && (term_code_s != EXIT_NONE);

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) state_s = ST_INIT;
        else                         state_s = ST_HOLD;
      end
      ST_INIT: state_s = ST_RUN;
      ST_RUN: begin
        if (term_s) state_s = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        else        state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) state_s = ST_DONE;
        else                           state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_DONE;
      default: state_s = ST_HOLD;
    endcase
  end

  // state register and phase timers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_HOLD;
      hold_cnt_r  <= '0;
      drain_cnt_r <= '0;
    end else begin
      state_r     <= state_s;
      hold_cnt_r  <= (state_r == ST_HOLD)  ? hold_cnt_r + HOLD_W'(1)   : '0;
      drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + DRAIN_W'(1) : '0;
    end
  end

  // run counters, latched limit and recorded exit cause
  always_ff @(posedge clock) begin
    if (reset) begin
      max_cycles_r <= 32'd0;
      cycle_cnt_r  <= 64'd0;
      instr_cnt_r  <= 64'd0;
      exit_code_r  <= EXIT_NONE;
    end else begin
      if (state_r == ST_INIT) begin
        max_cycles_r <= cfg_max_cycles;
      end else begin
        max_cycles_r <= max_cycles_r;
      end
      if (in_run_s) begin
        cycle_cnt_r <= cycle_cnt_r + 64'd1;
        instr_cnt_r <= instr_cnt_r + 64'(commit_cnt);
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
        instr_cnt_r <= instr_cnt_r;
      end
      if (term_s) begin
        exit_code_r <= term_code_s;
      end else begin
        exit_code_r <= exit_code_r;
      end
    end
  end

  assign core_reset = (state_r == ST_HOLD);
  assign init_req   = (state_r == ST_INIT);
  assign step_en    = in_run_s;
  assign finish     = (state_r == ST_DONE);
  assign exit_code  = exit_code_r;
  assign cycle_cnt  = cycle_cnt_r;
  assign instr_cnt  = instr_cnt_r;

endmodule
